// File: rtl/pri_pkg.sv
// Shared types and helpers for the priority/round-robin arbiter.
package pri_pkg;

   typedef enum logic {PRI_FIXED = 1'b0, PRI_RR = 1'b1} pri_mode_e;
   typedef enum logic {ST_EMPTY = 1'b0, ST_HOLD = 1'b1} pri_state_e;

   // Modulo-n decrement: 0 wraps to n-1, never to 2^W-1.
   function automatic int pri_wrap_dec(input int idx, input int n);
      return (idx == 0) ? n - 1 : idx - 1;
   endfunction

endpackage

// File: rtl/pri_rotate_enc.sv
// Combinational rotating priority search: slot `start` is highest priority,
// then start-1, ... wrapping modulo N.
module pri_rotate_enc #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic         found,
   output logic [W-1:0] idx
);

   logic [N-1:0] rot;
   logic [W-1:0] src;
   int           pos;

   // rot[N-1] is req[start], rot[N-2] is req[start-1], ... so the MSB wins.
   always_comb begin
      rot   = '0;
      src   = '0;
      found = 1'b0;
      pos   = 0;
      idx   = '0;
      for (int j = 0; j < N; j++) begin
         src    = W'((int'(start) + 1 + j) % N);
         rot[j] = req[src];
      end
      for (int j = 0; j < N; j++) begin
         if (rot[j]) begin
            found = 1'b1;
            pos   = j;
         end
      end
      if (found) begin
         idx = W'((int'(start) + 1 + pos) % N);
      end
   end

endmodule

// File: rtl/pri_arbiter.sv
// Registered N-way arbiter, fixed MSB-first or round-robin, with a
// valid/ready output register that holds each grant until accepted.
module pri_arbiter
   import pri_pkg::*;
#(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] out_onehot,
   output logic [W-1:0] ptr
);

   pri_state_e   state_q, state_d;
   logic [W-1:0] idx_q, idx_d;
   logic [N-1:0] oh_q, oh_d;
   logic [W-1:0] ptr_q, ptr_d;
   logic [W-1:0] start;
   logic         accept, load;
   logic         enc_found;
   logic [W-1:0] enc_idx;
   pri_mode_e    mode_e;

   assign mode_e = pri_mode_e'(mode);
   assign accept = (state_q == ST_HOLD) && out_ready;
   assign load   = (state_q == ST_EMPTY) || out_ready;

   pri_rotate_enc #(.N(N), .W(W)) u_enc (
      .req   (req),
      .start (start),
      .found (enc_found),
      .idx   (enc_idx)
   );

   // The search starts from the post-accept pointer, so a just-served slot
   // drops to lowest priority in the very same cycle.
   always_comb begin
      ptr_d   = ptr_q;
      state_d = state_q;
      idx_d   = idx_q;
      oh_d    = oh_q;
      if (accept && (mode_e == PRI_RR)) begin
         ptr_d = W'(pri_wrap_dec(int'(idx_q), N));
      end
      start = (mode_e == PRI_RR) ? ptr_d : W'(N - 1);
      if (load) begin
         if (enc_found) begin
            state_d        = ST_HOLD;
            idx_d          = enc_idx;
            oh_d           = '0;
            oh_d[enc_idx]  = 1'b1;
         end else begin
            state_d = ST_EMPTY;
            idx_d   = '0;
            oh_d    = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         idx_q   <= '0;
         oh_q    <= '0;
         ptr_q   <= W'(N - 1);
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         oh_q    <= oh_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_valid  = (state_q == ST_HOLD);
   assign out_idx    = idx_q;
   assign out_onehot = oh_q;
   assign ptr        = ptr_q;

endmodule

// File: tb/tb_pri_arbiter.sv
// Bench for pri_arbiter (N=8): directed vector table, hand-written corner
// sequences, then random stimulus against a behavioural reference model.
module tb_pri_arbiter;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic         mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_idx;
   logic [N-1:0] out_onehot;
   logic [W-1:0] ptr;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] req;
      logic       mode;
      logic       ready;
      logic       v;
      logic [2:0] idx;
      logic [7:0] oh;
      logic [2:0] p;
   } vec_t;

   vec_t vecs[$];

   // Reference model state: grant register contents and rotating pointer.
   bit m_valid;
   int m_idx;
   int m_ptr;

   pri_arbiter #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .mode       (mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_idx    (out_idx),
      .out_onehot (out_onehot),
      .ptr        (ptr)
   );

   always #5 clk = ~clk;

   function automatic void add(input logic [7:0] r, input logic m, input logic rdy,
                               input logic v, input logic [2:0] i, input logic [7:0] oh,
                               input logic [2:0] p);
      vec_t t;
      t.req = r; t.mode = m; t.ready = rdy; t.v = v; t.idx = i; t.oh = oh; t.p = p;
      vecs.push_back(t);
   endfunction

   function automatic void model_reset();
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = N - 1;
   endfunction

   // One clock edge of the arbiter, straight from the arbitration rules.
   function automatic void model_edge(input logic [7:0] r, input logic m, input logic rdy);
      bit acc;
      bit ld;
      int start;
      int p;
      acc = m_valid && rdy;
      ld  = !m_valid || rdy;
      if (acc && m) m_ptr = (m_idx == 0) ? N - 1 : m_idx - 1;
      if (ld) begin
         m_valid = 1'b0;
         m_idx   = 0;
         start   = m ? m_ptr : N - 1;
         for (int k = 0; k < N; k++) begin
            p = (start - k + N) % N;
            if (!m_valid && r[3'(p)]) begin
               m_valid = 1'b1;
               m_idx   = p;
            end
         end
      end
   endfunction

   task automatic check(input string name, input logic v, input logic [2:0] i,
                        input logic [7:0] oh, input logic [2:0] p);
      n_tests++;
      if (out_valid !== v || out_idx !== i || out_onehot !== oh || ptr !== p) begin
         n_fail++;
         $display("FAIL %s: got valid=%0b idx=%0d onehot=%h ptr=%0d, expected valid=%0b idx=%0d onehot=%h ptr=%0d",
                  name, out_valid, out_idx, out_onehot, ptr, v, i, oh, p);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      req       = '0;
      mode      = 1'b0;
      out_ready = 1'b0;
      step();
      check("reset", 1'b0, 3'd0, 8'h00, 3'd7);
      rst = 1'b0;

      // Idle after reset.
      for (int k = 0; k < 5; k++) add(8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 3'd7);
      // Fixed priority: bit 5 is the highest set bit.
      for (int k = 0; k < 3; k++) add(8'b0010_1001, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20, 3'd7);
      add(8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 3'd7);
      // Round-robin, all requesting: 7,6,...,0,7,6.
      add(8'hFF, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 3'd7);
      for (int g = 6; g >= 0; g--) add(8'hFF, 1'b1, 1'b1, 1'b1, 3'(g), 8'(1 << g), 3'(g));
      add(8'hFF, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 3'd7);
      add(8'hFF, 1'b1, 1'b1, 1'b1, 3'd6, 8'h40, 3'd6);
      // Round-robin between slots 7 and 0.
      add(8'h81, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 3'd5);
      add(8'h81, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 3'd7);
      add(8'h81, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 3'd6);
      add(8'h81, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 3'd7);
      add(8'h81, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 3'd6);
      // Switch to fixed: 7 every time, pointer frozen.
      for (int k = 0; k < 3; k++) add(8'h81, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80, 3'd6);
      // Backpressure: grant 3 frozen while req wanders.
      add(8'h08, 1'b0, 1'b1, 1'b1, 3'd3, 8'h08, 3'd6);
      add(8'h80, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 3'd6);
      add(8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 3'd6);
      add(8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 3'd6);
      add(8'h80, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 3'd6);
      add(8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 3'd6);

      foreach (vecs[i]) begin
         req       = vecs[i].req;
         mode      = vecs[i].mode;
         out_ready = vecs[i].ready;
         step();
         check($sformatf("vec%0d", i), vecs[i].v, vecs[i].idx, vecs[i].oh, vecs[i].p);
      end

      // Walk round-robin down to slot 2, then re-grant 2 with ptr=1.
      req = 8'hFF; mode = 1'b1; out_ready = 1'b1;
      repeat (5) step();
      check("rr_walk_to_2", 1'b1, 3'd2, 8'h04, 3'd2);
      req = 8'h04;
      step();
      check("rr_regrant_2", 1'b1, 3'd2, 8'h04, 3'd1);
      out_ready = 1'b0;
      req       = 8'hFF;
      step();
      check("hold_before_rst", 1'b1, 3'd2, 8'h04, 3'd1);
      #3 rst = 1'b1;
      #1;
      check("rst_async", 1'b0, 3'd0, 8'h00, 3'd7);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      step();
      check("first_after_rst", 1'b1, 3'd7, 8'h80, 3'd7);

      // Random stimulus against the reference model.
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < 400; c++) begin
         req       = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom) & 8'($urandom);
         mode      = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         step();
         model_edge(req, mode, out_ready);
         check($sformatf("rand%0d", c), m_valid, 3'(m_idx),
               m_valid ? 8'(1 << m_idx) : 8'h00, 3'(m_ptr));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
